// File: rtl/i_mem_prefetch_pkg.sv
// Shared definitions for the prefetching instruction memory: control state
// encoding and the index-width helpers used to size the RAM.
package i_mem_prefetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // no read in flight
        ST_READ = 2'd1,  // demand read in flight
        ST_PREF = 2'd2   // prefetch read in flight, buffer word is RAM output
    } state_e;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2_fn(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // RAM index width; never zero so a single-word memory still has an index.
    function automatic int idx_width(input int depth);
        return (clog2_fn(depth) < 1) ? 1 : clog2_fn(depth);
    endfunction

endpackage

// File: rtl/i_mem_prefetch_if.sv
// Fetch and program-load bus between the CPU fetch stage / bootloader
// (master) and the instruction memory (slave).
//
// Handshake: the master raises i_req with i_addr and holds i_addr stable
// until the cycle in which i_ack=1; i_ack is combinational and the word is
// transferred in that same cycle. i_rdata and i_oob are meaningful only when
// i_ack=1 and read as zero otherwise. ld_we is a single-cycle write strobe
// with no back-pressure. dbg_state mirrors the memory's control state.
interface i_mem_prefetch_if
    import i_mem_prefetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_ack;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  i_oob;
    logic                  ld_we;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [DATA_WIDTH-1:0] ld_data;
    state_e                dbg_state;

    modport master (
        output i_req, i_addr, ld_we, ld_addr, ld_data,
        input  i_ack, i_rdata, i_oob, dbg_state
    );

    modport slave (
        input  i_req, i_addr, ld_we, ld_addr, ld_data,
        output i_ack, i_rdata, i_oob, dbg_state
    );
endinterface

// File: rtl/i_mem_prefetch_ram.sv
// Single-port synchronous RAM: one access per cycle, write wins over read,
// read data appears the cycle after the address is presented.
module i_mem_prefetch_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int IDX_W      = 8
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Port access: write when we_i, otherwise register the read word.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[idx_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/i_mem_prefetch.sv
// Instruction memory with a one-entry sequential prefetch buffer and a
// run-time program-load port. Out-of-range fetches return FILL_DATA with
// i_oob set instead of aliasing into the array.
module i_mem_prefetch
    import i_mem_prefetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    MEM_DEPTH  = 256,
    parameter logic [DATA_WIDTH-1:0] FILL_DATA  = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    i_mem_prefetch_if.slave bus
);
    localparam int                  IDX_W     = idx_width(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0] pf_addr_q, pf_addr_d;
    logic                  pf_valid_q, pf_valid_d;
    logic [DATA_WIDTH-1:0] pf_data_q;

    logic                  ram_en, ram_we;
    logic [IDX_W-1:0]      ram_idx;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic                  fetch_in_range, ld_in_range;
    logic [ADDR_WIDTH-1:0] nxt_addr;
    logic                  nxt_carry;
    logic                  no_prefetch;
    logic [DATA_WIDTH-1:0] pf_word;
    logic                  ack, oob, ack_in;
    logic [DATA_WIDTH-1:0] rdata;

    // Range checks are done one bit wider so MEM_DEPTH == 2^ADDR_WIDTH works.
    assign fetch_in_range = ({1'b0, bus.i_addr} < DEPTH_EXT);
    assign ld_in_range    = ({1'b0, bus.ld_addr} < DEPTH_EXT);

    // Next sequential address; a carry out or reaching MEM_DEPTH stops prefetch.
    assign {nxt_carry, nxt_addr} = {1'b0, bus.i_addr} + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign no_prefetch = nxt_carry || ({1'b0, nxt_addr} == DEPTH_EXT);

    // While the prefetch read is in flight the buffer word is the RAM output.
    assign pf_word = (state_q == ST_PREF) ? ram_rdata : pf_data_q;

    i_mem_prefetch_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .idx_i   (ram_idx),
        .wdata_i (bus.ld_data),
        .rdata_o (ram_rdata)
    );

    // Control: load, out-of-range, demand-read match, buffer hit, miss, prefetch.
    always_comb begin
        state_d    = ST_IDLE;
        rd_addr_d  = rd_addr_q;
        pf_addr_d  = pf_addr_q;
        pf_valid_d = pf_valid_q;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_idx    = bus.i_addr[IDX_W-1:0];
        ack        = 1'b0;
        oob        = 1'b0;
        ack_in     = 1'b0;
        rdata      = '0;

        // Out-of-range fetches never touch the RAM or the buffer.
        if (bus.i_req && !fetch_in_range) begin
            ack   = 1'b1;
            oob   = 1'b1;
            rdata = FILL_DATA;
        end

        if (bus.ld_we) begin
            // A load invalidates everything that might hold the old word.
            pf_valid_d = 1'b0;
            state_d    = ST_IDLE;
            if (ld_in_range) begin
                ram_en  = 1'b1;
                ram_we  = 1'b1;
                ram_idx = bus.ld_addr[IDX_W-1:0];
            end
        end else if (bus.i_req && fetch_in_range) begin
            if (state_q == ST_READ && rd_addr_q == bus.i_addr) begin
                ack    = 1'b1;
                ack_in = 1'b1;
                rdata  = ram_rdata;
            end else if (pf_valid_q && pf_addr_q == bus.i_addr) begin
                ack    = 1'b1;
                ack_in = 1'b1;
                rdata  = pf_word;
            end else begin
                ram_en    = 1'b1;
                ram_idx   = bus.i_addr[IDX_W-1:0];
                rd_addr_d = bus.i_addr;
                state_d   = ST_READ;
                if (state_q == ST_PREF) begin
                    pf_valid_d = 1'b0;
                end
            end

            if (ack_in) begin
                if (no_prefetch) begin
                    pf_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    ram_en     = 1'b1;
                    ram_idx    = nxt_addr[IDX_W-1:0];
                    pf_addr_d  = nxt_addr;
                    pf_valid_d = 1'b1;
                    state_d    = ST_PREF;
                end
            end
        end
    end

    // Control state, addresses and buffer valid; reset cancels reads in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rd_addr_q  <= '0;
            pf_addr_q  <= '0;
            pf_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            pf_addr_q  <= pf_addr_d;
            pf_valid_q <= pf_valid_d;
        end
    end

    // Capture the prefetched word at the end of its bypass cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_data_q <= '0;
        end else if (state_q == ST_PREF) begin
            pf_data_q <= ram_rdata;
        end
    end

    assign bus.i_ack     = rst_n & ack;
    assign bus.i_oob     = rst_n & oob;
    assign bus.i_rdata   = rst_n ? rdata : '0;
    assign bus.dbg_state = state_q;
endmodule
